// File: rtl/frame_crop_decimate_if.sv
// Pixel-stream and image-FIFO write bus for frame_crop_decimate.
// master: camera feeder / FIFO side, slave: the crop/decimate block.
interface frame_crop_decimate_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [23:0] in_data;
  logic        out_wr_en;
  logic        out_full;
  logic [23:0] out_din;

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_full,
    input  in_ready, out_wr_en, out_din
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_full,
    output in_ready, out_wr_en, out_din
  );
endinterface

// File: rtl/frame_crop_decimate.sv
// Crops a window out of each raw RGB frame, decimates it by DECIM in both axes
// and writes exactly WIDTH*HEIGHT pixels per frame into the image FIFO.
// Short frames are zero-padded, overlong frames are flushed to their eop.
// The write path is combinational so the FIFO sees each kept pixel in the
// cycle it is accepted.
module frame_crop_decimate #(
  parameter int unsigned IN_WIDTH  = 1280,
  parameter int unsigned IN_HEIGHT = 720,
  parameter int unsigned CROP_X    = 128,
  parameter int unsigned CROP_Y    = 72,
  parameter int unsigned DECIM     = 2,
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned HEIGHT    = 288
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  frame_crop_decimate_if.slave  io_pix,
  output logic                  o_frame_done,
  output logic [15:0]           o_short_frames,
  output logic [15:0]           o_long_frames
);

  localparam int unsigned CROP_W = WIDTH * DECIM;
  localparam int unsigned CROP_H = HEIGHT * DECIM;
  localparam int unsigned N_OUT  = WIDTH * HEIGHT;
  localparam int unsigned XW     = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int unsigned YW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned CW     = $clog2(N_OUT + 1);
  localparam int unsigned DW     = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_PAD,
    S_FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XW-1:0]   r_x;
  logic [XW-1:0]   w_x_nxt;
  logic [XW-1:0]   w_px;
  logic [YW-1:0]   r_y;
  logic [YW-1:0]   w_y_nxt;
  logic [YW-1:0]   w_py;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_count_base;
  logic [CW-1:0]   w_count_inc;
  logic            r_capture;
  logic            w_capture_nxt;
  logic            w_cap;
  logic [15:0]     r_short;
  logic [15:0]     w_short_nxt;
  logic [15:0]     r_long;
  logic [15:0]     w_long_nxt;

  logic [31:0]     w_px32;
  logic [31:0]     w_py32;
  logic [31:0]     w_dx;
  logic [31:0]     w_dy;
  logic            w_keep;
  logic            w_last;
  logic            w_origin;
  logic            w_proc;
  logic            w_ready;
  logic            w_wr;
  logic            w_done;
  logic [DW-1:0]   w_din;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Position, capture flag and write count that apply to the pixel on the bus;
  // in IDLE an sop pixel is treated as the first pixel of a fresh frame.
  always_comb begin
    w_px         = r_x;
    w_py         = r_y;
    w_cap        = r_capture;
    w_count_base = r_count;
    if (r_state == S_IDLE) begin
      w_px         = '0;
      w_py         = '0;
      w_cap        = i_enable;
      w_count_base = '0;
    end
  end

  assign w_px32      = 32'(w_px);
  assign w_py32      = 32'(w_py);
  assign w_dx        = w_px32 - CROP_X;
  assign w_dy        = w_py32 - CROP_Y;
  assign w_count_inc = w_count_base + CW'(1);
  assign w_last      = (w_px == XW'(IN_WIDTH - 1)) && (w_py == YW'(IN_HEIGHT - 1));
  assign w_origin    = (r_x == '0) && (r_y == '0);

  // Window membership plus decimation phase; DECIM is a power of two so the
  // modulo reduces to a mask.
  assign w_keep = w_cap
               && (w_px32 >= CROP_X) && (w_px32 < CROP_X + CROP_W)
               && (w_py32 >= CROP_Y) && (w_py32 < CROP_Y + CROP_H)
               && ((w_dx & (DECIM - 1)) == 32'd0)
               && ((w_dy & (DECIM - 1)) == 32'd0);

  // Next-state, counters and the combinational handshake/write strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_count_nxt   = r_count;
    w_capture_nxt = r_capture;
    w_short_nxt   = r_short;
    w_long_nxt    = r_long;
    w_ready       = 1'b1;
    w_proc        = 1'b0;
    w_wr          = 1'b0;
    w_done        = 1'b0;
    w_din         = '0;

    unique case (r_state)
      S_IDLE: begin
        // Non-sop pixels are swallowed; an sop pixel opens a frame.
        w_proc = io_pix.in_valid && io_pix.in_sop;
        if (w_proc) begin
          w_capture_nxt = i_enable;
        end
      end

      S_ACTIVE: begin
        if (io_pix.in_valid && io_pix.in_sop && !w_origin) begin
          // Early sop: hold it off, close this frame out by padding.
          w_ready     = 1'b0;
          w_short_nxt = sat_inc(r_short);
          w_state_nxt = S_PAD;
        end else begin
          // Only a pixel that would be written waits for FIFO space.
          w_ready = !(w_keep && io_pix.out_full);
          w_proc  = io_pix.in_valid && w_ready;
        end
      end

      S_PAD: begin
        w_ready = 1'b0;
        if (!r_capture || (32'(r_count) >= N_OUT)) begin
          w_state_nxt = S_IDLE;
        end else if (!io_pix.out_full) begin
          w_wr        = 1'b1;
          w_din       = '0;
          w_count_nxt = w_count_inc;
          if (32'(w_count_inc) == N_OUT) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        if (io_pix.in_valid && io_pix.in_sop) begin
          // Leave the sop pending so IDLE can take it next cycle.
          w_ready     = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (io_pix.in_valid && io_pix.in_eop) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common handling of an accepted in-frame pixel (IDLE sop or ACTIVE).
    if (w_proc) begin
      w_count_nxt = w_count_base;
      if (w_keep) begin
        w_wr        = 1'b1;
        w_din       = io_pix.in_data;
        w_count_nxt = w_count_inc;
        w_done      = (32'(w_count_inc) == N_OUT);
      end

      if (w_px == XW'(IN_WIDTH - 1)) begin
        w_x_nxt = '0;
        w_y_nxt = (w_py == YW'(IN_HEIGHT - 1)) ? '0 : w_py + YW'(1);
      end else begin
        w_x_nxt = w_px + XW'(1);
        w_y_nxt = w_py;
      end

      if (io_pix.in_eop) begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_short_nxt = sat_inc(r_short);
          w_state_nxt = S_PAD;
        end
      end else if (w_last) begin
        w_long_nxt  = sat_inc(r_long);
        w_state_nxt = S_FLUSH;
      end else begin
        w_state_nxt = S_ACTIVE;
      end
    end

    // Hold the FIFO side quiet while the block is in reset.
    if (i_reset) begin
      w_ready = 1'b1;
      w_wr    = 1'b0;
      w_done  = 1'b0;
      w_din   = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_count   <= '0;
      r_capture <= 1'b0;
      r_short   <= '0;
      r_long    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_count   <= w_count_nxt;
      r_capture <= w_capture_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
    end
  end

  assign io_pix.in_ready  = w_ready;
  assign io_pix.out_wr_en = w_wr;
  assign io_pix.out_din   = w_din;
  assign o_frame_done     = w_done;
  assign o_short_frames   = r_short;
  assign o_long_frames    = r_long;

endmodule

// File: doc/frame_crop_decimate.md
Name: frame_crop_decimate

Overview:
Upstream feeder for the lane-detection pipeline's 24-bit image input FIFO (the FIFO ahead of grayscale). It accepts a raw RGB camera pixel stream with start/end-of-frame markers and crops a window from each frame. It decimates that window by DECIM in both axes. It writes exactly WIDTH*HEIGHT pixels per frame into the FIFO, so downstream stages always see a full frame. Malformed frames are padded or flushed so the per-frame pixel count never drifts.

Parameters:
IN_WIDTH, 1280, input frame width in pixels
IN_HEIGHT, 720, input frame height in pixels
CROP_X, 128, first input column of the window
CROP_Y, 72, first input row of the window
DECIM, 2, decimation factor, power of two (1, 2, 4)
WIDTH, 512, output width; CROP_X+WIDTH*DECIM <= IN_WIDTH is required
HEIGHT, 288, output height; CROP_Y+HEIGHT*DECIM <= IN_HEIGHT is required

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  frame capture enable, sampled only in IDLE on an accepted sop pixel
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_sop  in  1  first pixel of input frame
in_eop  in  1  last pixel of input frame
in_data  in  24  RGB pixel {R,G,B}
out_wr_en  out  1  write strobe to image FIFO
out_full  in  1  image FIFO full
out_din  out  24  pixel to image FIFO
frame_done  out  1  one-cycle pulse on the WIDTH*HEIGHT-th write of a frame
short_frames  out  16  saturating count of truncated frames
long_frames  out  16  saturating count of overlong frames

Behaviour:
- Registered state: state, in_x, in_y, out_count, capture flag, short_frames, long_frames.
- Reset: state=IDLE and all counters=0. Outputs: out_wr_en=0, frame_done=0, in_ready=1, out_din=0.
- keep (combinational) = capture && in_x in [CROP_X, CROP_X+WIDTH*DECIM) && in_y in [CROP_Y, CROP_Y+HEIGHT*DECIM) && ((in_x-CROP_X) mod DECIM)==0 && ((in_y-CROP_Y) mod DECIM)==0.
- Write path is zero latency (FIFO-style). out_wr_en = accepted pixel && keep in ACTIVE, and out_din = in_data that cycle. In PAD: out_wr_en = !out_full and out_din = 0. Otherwise out_din is don't-care.
- in_ready by state:
  - IDLE: 1.
  - ACTIVE: !(keep && out_full). Dropped pixels are never stalled.
  - PAD: 0.
  - FLUSH: 1.
- IDLE:
  - Accepted pixels without sop are discarded.
  - An accepted sop pixel sets capture=enable, in_x=in_y=out_count=0, and processes that pixel as pixel (0,0) (written if keep). Next state is ACTIVE, or PAD/IDLE if the same pixel also carries eop.
- ACTIVE:
  - Each accepted pixel increments in_x. It wraps at IN_WIDTH-1, incrementing in_y. out_count increments on every write.
  - If in_sop is presented (valid) and the frame is not at (0,0), the pixel is NOT accepted (in_ready forced 0 that cycle). short_frames++, next state PAD.
  - Accepted eop before the last input pixel: that pixel is processed first, short_frames++, next state PAD.
  - Last input pixel (IN_WIDTH*IN_HEIGHT-1) with eop goes to IDLE.
  - Last input pixel without eop: long_frames++, next state FLUSH.
- PAD:
  - Writes zeros until out_count==WIDTH*HEIGHT, then goes to IDLE. The pending sop pixel is then accepted in IDLE.
  - If capture=0, PAD goes straight to IDLE with no writes and no frame_done.
- FLUSH:
  - Discards pixels until an accepted eop, then goes to IDLE.
  - A valid sop in FLUSH is not accepted; state goes to IDLE, which accepts it next cycle.
- frame_done asserts only with the write that makes out_count reach WIDTH*HEIGHT, whether a real or a pad write.
- Simultaneous sop and eop on one accepted pixel is a 1-pixel frame: short_frames++ (unless IN_WIDTH*IN_HEIGHT==1), then PAD.
- Counters saturate at 16'hFFFF.
- Reset mid-frame aborts with no padding. The downstream FIFO is reset by the same reset.

Test Plan:
Test params for all scenarios: IN_WIDTH=8, IN_HEIGHT=6, CROP_X=1, CROP_Y=1, DECIM=2, WIDTH=3, HEIGHT=2. in_data=pixel index.
1. Clean frame, enable=1, out_full=0 -> writes 9,11,13,25,27,29 in order; frame_done pulses with the write of 29; both error counters stay 0.
2. Same frame with out_full held high for 5 cycles at the write of index 11 -> in_ready=0 only while keep&&out_full; no write lost or duplicated; output sequence unchanged.
3. Frame with eop at index 20 -> writes 9,11,13 then 0,0,0 in PAD; frame_done on the last pad write; short_frames=1.
4. Frame of 50 pixels, eop on index 49 -> 6 real writes; long_frames=1; pixels 48-49 discarded; next sop frame outputs normally.
5. Frame truncated by a new sop at index 30 -> writes 9,11,13,25,27,29 with no pad needed; short_frames=1; the sop pixel is held and the new frame is processed fully.
6. enable=0 at sop -> zero writes and no frame_done; in_ready=1 throughout; enable=1 on the next frame gives normal output.
